pir_sensor_frontend: RTL

//  Produces the three 7-bit PIR motion levels consumed by the motion alarm controller, from three raw 1-bit PIR pins.
//  Per sensor: level = count of high cycles in a fixed sample window, updated once per window with a valid strobe.

---
 rtl/pir_pkg.sv | 21 ++
 rtl/pir_channel.sv | 109 ++++++++++
 rtl/pir_sensor_frontend.sv | 78 +++++++
 3 files changed

// File: rtl/pir_pkg.sv
// Shared PIR constants and level type, used by the sensor front end and the motion alarm controller.
package pir_pkg;

  localparam int NUM_PIR           = 3;
  localparam int PIR_LEVEL_W       = 7;
  localparam int PIR_LEVEL_MAX     = 127;
  localparam int PIR_TRIGGER_LEVEL = 50;

  typedef logic [PIR_LEVEL_W-1:0] pir_level_t;

  // The level range is a full power of two, so a carry out means saturation.
  function automatic pir_level_t sat_add(input pir_level_t a, input logic b);
    logic [PIR_LEVEL_W:0] sum;
    sum = {1'b0, a} + {{PIR_LEVEL_W{1'b0}}, b};
    if (sum[PIR_LEVEL_W]) begin
      return '1;
    end
    return sum[PIR_LEVEL_W-1:0];
  endfunction

endpackage

// File: rtl/pir_channel.sv
// One PIR sensor: 2-flop synchronizer, optional glitch filter (PIR_GLITCH_FILTER_EN),
// per-window high-cycle counter and stuck-high detection with a sticky fault flag.
module pir_channel
  import pir_pkg::*;
#(
  parameter int WINDOW_CYCLES = 100,
  parameter int STUCK_WINDOWS = 4
`ifdef PIR_GLITCH_FILTER_EN
  ,
  parameter int FILTER_CYCLES = 3
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       pin,
  input  logic       win_end,
  output pir_level_t level,
  output logic       fault
);

  localparam int STUCK_W = $clog2(STUCK_WINDOWS + 1);

  logic [1:0]         sync;
  logic               synced;
  logic               sample;
  pir_level_t         hi_cnt;
  pir_level_t         raw_level;
  logic [STUCK_W-1:0] stuck_cnt;
  logic [STUCK_W-1:0] stuck_next;
  logic               fault_next;

  // The synchronizer keeps running while disarmed so the first armed sample is valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
    end else begin
      sync <= {sync[0], pin};
    end
  end

  assign synced = sync[1];

`ifdef PIR_GLITCH_FILTER_EN
  localparam int FILT_W = $clog2(FILTER_CYCLES + 1);

  logic              filt;
  logic [FILT_W-1:0] filt_cnt;

  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      filt     <= 1'b0;
      filt_cnt <= '0;
    end else if (synced != filt) begin
      if (filt_cnt == FILT_W'(FILTER_CYCLES - 1)) begin
        filt     <= synced;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end else begin
      filt_cnt <= '0;
    end
  end

  assign sample = filt;
`else
  assign sample = synced;
`endif

  // The window-end sample goes into the reported level, so the counter restarts from zero.
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      hi_cnt <= '0;
    end else if (win_end) begin
      hi_cnt <= '0;
    end else begin
      hi_cnt <= sat_add(hi_cnt, sample);
    end
  end

  assign raw_level = sat_add(hi_cnt, sample);

  always_comb begin
    stuck_next = '0;
    if (raw_level == pir_level_t'(WINDOW_CYCLES)) begin
      if (stuck_cnt == STUCK_W'(STUCK_WINDOWS)) begin
        stuck_next = stuck_cnt;
      end else begin
        stuck_next = stuck_cnt + 1'b1;
      end
    end
    fault_next = fault || (stuck_next == STUCK_W'(STUCK_WINDOWS));
  end

  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      stuck_cnt <= '0;
      fault     <= 1'b0;
    end else if (win_end) begin
      stuck_cnt <= stuck_next;
      fault     <= fault_next;
    end
  end

  // A sensor is silenced already on the update that flags it.
  assign level = fault_next ? '0 : raw_level;

endmodule

// File: rtl/pir_sensor_frontend.sv
// Turns three raw PIR pins into windowed 7-bit motion levels with a shared valid strobe.
// Define PIR_GLITCH_FILTER_EN to add the per-channel glitch filter.
module pir_sensor_frontend
  import pir_pkg::*;
#(
  parameter int WINDOW_CYCLES = 100,
  parameter int STUCK_WINDOWS = 4
`ifdef PIR_GLITCH_FILTER_EN
  ,
  parameter int FILTER_CYCLES = 3
`endif
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [NUM_PIR-1:0]     pir_raw,
  output logic [PIR_LEVEL_W-1:0] pir_sensor_1,
  output logic [PIR_LEVEL_W-1:0] pir_sensor_2,
  output logic [PIR_LEVEL_W-1:0] pir_sensor_3,
  output logic                   level_valid,
  output logic [NUM_PIR-1:0]     fault
);

  localparam int WIN_W = $clog2(WINDOW_CYCLES);

  logic [WIN_W-1:0] win_cnt;
  logic             win_end;
  pir_level_t       levels [NUM_PIR];

  assign win_end = enable && (win_cnt == WIN_W'(WINDOW_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      win_cnt <= '0;
    end else if (win_end) begin
      win_cnt <= '0;
    end else begin
      win_cnt <= win_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_PIR; i++) begin : g_chan
    pir_channel #(
      .WINDOW_CYCLES(WINDOW_CYCLES),
      .STUCK_WINDOWS(STUCK_WINDOWS)
`ifdef PIR_GLITCH_FILTER_EN
      ,
      .FILTER_CYCLES(FILTER_CYCLES)
`endif
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .enable (enable),
      .pin    (pir_raw[i]),
      .win_end(win_end),
      .level  (levels[i]),
      .fault  (fault[i])
    );
  end

  // Levels hold between window ends; a partial window never produces an update.
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      pir_sensor_1 <= '0;
      pir_sensor_2 <= '0;
      pir_sensor_3 <= '0;
      level_valid  <= 1'b0;
    end else begin
      level_valid <= win_end;
      if (win_end) begin
        pir_sensor_1 <= levels[0];
        pir_sensor_2 <= levels[1];
        pir_sensor_3 <= levels[2];
      end
    end
  end

endmodule
